// File: rtl/post_neuron_pkg.sv
// Shared types and constants for the post-neuron read-modify-write controller.
package post_neuron_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StClear
    } state_e;

    // Default packed-word layout: membrane in the low half, spike count above it.
    localparam int unsigned MEM_LSB = 0;
    localparam int unsigned MEM_MSB = 15;
    localparam int unsigned CNT_LSB = 16;
    localparam int unsigned CNT_MSB = 31;

    function automatic int sat_max(input int unsigned w);
        return (32'sd1 <<< (w - 1)) - 32'sd1;
    endfunction

    function automatic int sat_min(input int unsigned w);
        return -(32'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/post_neuron_update_alu.sv
// Combinational neuron update: optional leak, saturating integrate, threshold fire.
// Leak is compiled in only when POST_NEURON_LEAK_EN is defined.
module post_neuron_update_alu
    import post_neuron_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_W      = 16,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WGT_W      = 16,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [WGT_W-1:0]      wgt,
    input  logic [MEM_W-1:0]      vth,
    output logic [DATA_WIDTH-1:0] new_word,
    output logic                  fire
);

    localparam logic signed [MEM_W:0] VMAX = (MEM_W + 1)'(sat_max(MEM_W));
    localparam logic signed [MEM_W:0] VMIN = (MEM_W + 1)'(sat_min(MEM_W));

    logic signed [MEM_W-1:0] v_old;
    logic signed [MEM_W-1:0] v_lk;
    logic signed [MEM_W-1:0] v_new;
    logic signed [MEM_W:0]   sum;
    logic [CNT_W-1:0]        cnt_old;
    logic [CNT_W-1:0]        cnt_new;

    always_comb begin
        v_old = $signed(old_word[MEM_W-1:0]);
`ifdef POST_NEURON_LEAK_EN
        v_lk = v_old - (v_old >>> LEAK_SHIFT);
`else
        v_lk = v_old;
`endif
        // One guard bit is enough: both operands fit in MEM_W signed bits.
        sum = {v_lk[MEM_W-1], v_lk} + (MEM_W + 1)'($signed(wgt));
        if (sum > VMAX) begin
            v_new = VMAX[MEM_W-1:0];
        end else if (sum < VMIN) begin
            v_new = VMIN[MEM_W-1:0];
        end else begin
            v_new = sum[MEM_W-1:0];
        end

        fire = (v_new >= $signed(vth));

        cnt_old = old_word[DATA_WIDTH-1:MEM_W];
        cnt_new = cnt_old;
        if (fire && !(&cnt_old)) begin
            cnt_new = cnt_old + CNT_W'(1);
        end

        if (fire) begin
            new_word = {cnt_new, {MEM_W{1'b0}}};
        end else begin
            new_word = {cnt_new, v_new};
        end
    end

endmodule

// File: rtl/post_neuron_update_ctrl.sv
// Post-neuron SRAM read-modify-write controller with sequential clear sweep.
// Optional membrane leak in the ALU is enabled by POST_NEURON_LEAK_EN.
module post_neuron_update_ctrl
    import post_neuron_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SRAM_DEPTH = 256,
    parameter int unsigned MEM_W      = MEM_MSB - MEM_LSB + 1,
    parameter int unsigned CNT_W      = CNT_MSB - CNT_LSB + 1,
    parameter int unsigned WGT_W      = 16,
    parameter int unsigned LEAK_SHIFT = 4
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_idx,
    input  logic [WGT_W-1:0]      in_wgt,
    input  logic [MEM_W-1:0]      vth,
    input  logic                  clr_start,
    output logic                  clr_done,
    output logic                  busy,
    output logic                  spike_valid,
    output logic [ADDR_WIDTH-1:0] spike_idx,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(SRAM_DEPTH - 1);

    state_e                state_q, state_d;
    logic                  cs_q, cs_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [WGT_W-1:0]      wgt_q, wgt_d;
    logic                  spike_valid_q, spike_valid_d;
    logic [ADDR_WIDTH-1:0] spike_idx_q, spike_idx_d;
    logic                  clr_done_q, clr_done_d;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] alu_word;
    logic                  alu_fire;

    post_neuron_update_alu #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_W     (MEM_W),
        .CNT_W     (CNT_W),
        .WGT_W     (WGT_W),
        .LEAK_SHIFT(LEAK_SHIFT)
    ) u_alu (
        .old_word(sram_q),
        .wgt     (wgt_q),
        .vth     (vth),
        .new_word(alu_word),
        .fire    (alu_fire)
    );

    always_comb begin
        state_d       = state_q;
        cs_d          = 1'b0;
        we_d          = 1'b0;
        a_d           = a_q;
        d_d           = d_q;
        wgt_d         = wgt_q;
        spike_valid_d = 1'b0;
        spike_idx_d   = spike_idx_q;
        clr_done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cs_d    = 1'b1;
                    we_d    = 1'b1;
                    a_d     = '0;
                    d_d     = '0;
                end else if (in_valid) begin
                    state_d = StRead;
                    cs_d    = 1'b1;
                    a_d     = in_idx;
                    wgt_d   = in_wgt;
                end
            end
            StRead: begin
                state_d = StWrite;
                cs_d    = 1'b1;
                we_d    = 1'b1;
            end
            StWrite: begin
                state_d       = StIdle;
                d_d           = alu_word;
                spike_valid_d = alu_fire;
                if (alu_fire) begin
                    spike_idx_d = a_q;
                end
            end
            StClear: begin
                if (a_q == CLR_LAST) begin
                    state_d    = StIdle;
                    clr_done_d = 1'b1;
                end else begin
                    cs_d = 1'b1;
                    we_d = 1'b1;
                    a_d  = a_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q       <= StIdle;
            cs_q          <= 1'b0;
            we_q          <= 1'b0;
            a_q           <= '0;
            d_q           <= '0;
            wgt_q         <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            clr_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cs_q          <= cs_d;
            we_q          <= we_d;
            a_q           <= a_d;
            d_q           <= d_d;
            wgt_q         <= wgt_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            clr_done_q    <= clr_done_d;
            busy_q        <= (state_d != StIdle);
        end
    end

    assign in_ready    = (state_q == StIdle) & ~clr_start;
    assign busy        = busy_q;
    assign clr_done    = clr_done_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign sram_a      = a_q;
    // A reset cycle must never let an in-flight write reach the array.
    assign sram_cs     = cs_q & ~RST;
    assign sram_we     = we_q & ~RST;
    // Read data arrives in WRITE, so the new word goes out the same cycle.
    assign sram_d      = (state_q == StWrite) ? alu_word : d_q;

endmodule

// File: tb/tb_post_neuron_update_ctrl.sv
// Self-checking bench: SRAM model plus arithmetic reference of the neuron update rules.
module tb_post_neuron_update_ctrl;

    localparam int LEAK_SHIFT = 4;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_idx = '0;
    logic [15:0] in_wgt = '0;
    logic [15:0] vth = 16'd10;
    logic        clr_start = 1'b0;
    logic        clr_done;
    logic        busy;
    logic        spike_valid;
    logic [7:0]  spike_idx;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_a;
    logic [31:0] sram_d;
    logic [31:0] sram_q;

    logic        pre_we = 1'b0;
    logic [7:0]  pre_a = '0;
    logic [31:0] pre_d = '0;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic [7:0]  last_spike = '0;
    int          total = 0;
    int          bad = 0;

    always #5 CK = ~CK;

    post_neuron_update_ctrl #(
        .LEAK_SHIFT(LEAK_SHIFT)
    ) dut (
        .CK         (CK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_wgt     (in_wgt),
        .vth        (vth),
        .clr_start  (clr_start),
        .clr_done   (clr_done),
        .busy       (busy),
        .spike_valid(spike_valid),
        .spike_idx  (spike_idx),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    // Synchronous single-port SRAM with a bench-side preload port.
    always @(posedge CK) begin
        if (pre_we) begin
            mem[pre_a] <= pre_d;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_a] <= sram_d;
            else         sram_q <= mem[sram_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_update(input logic [31:0] old, input logic [15:0] w,
                                               input logic [15:0] th, output bit f);
        int v;
        int c;
        v = int'($signed(old[15:0]));
`ifdef POST_NEURON_LEAK_EN
        v = v - (v >>> LEAK_SHIFT);
`endif
        v = v + int'($signed(w));
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        f = (v >= int'($signed(th)));
        c = int'(old[31:16]);
        if (f) begin
            if (c < 65535) c = c + 1;
            v = 0;
        end
        return {c[15:0], v[15:0]};
    endfunction

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge CK);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge CK);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    // Waits for in_ready and presents the event; acceptance is the next posedge.
    task automatic issue(input logic [7:0] idx, input logic [15:0] w, input logic [15:0] th,
                         output bit ok);
        int n = 0;
        @(negedge CK);
        while (!in_ready && n < 20) begin
            @(negedge CK);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            check("ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        vth      = th;
        in_valid = 1'b1;
        in_idx   = idx;
        in_wgt   = w;
    endtask

    // Cycle-accurate checks from acceptance through T+3.
    task automatic tail(input logic [7:0] idx, input logic [15:0] w);
        logic [31:0] exp;
        bit          f;
        exp = ref_update(ref_mem[idx], w, vth, f);
        @(posedge CK);
        @(negedge CK);
        in_valid = 1'b0;
        check("rd_ctl", {29'd0, sram_cs, sram_we, busy}, {29'd0, 3'b101});
        check("rd_a", 32'(sram_a), 32'(idx));
        @(negedge CK);
        check("wr_ctl", {30'd0, sram_cs, sram_we}, 32'd3);
        check("wr_a", 32'(sram_a), 32'(idx));
        check("wr_d", sram_d, exp);
        @(negedge CK);
        if (f) last_spike = idx;
        check("spk_v", 32'(spike_valid), 32'(f));
        check("spk_idx", 32'(spike_idx), 32'(last_spike));
        check("rdy_t3", {30'd0, in_ready, sram_cs}, 32'd2);
        check("mem_wb", mem[idx], exp);
        ref_mem[idx] = exp;
    endtask

    task automatic event_chk(input logic [7:0] idx, input logic [15:0] w, input logic [15:0] th);
        bit ok;
        issue(idx, w, th, ok);
        if (ok) tail(idx, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nz;
        for (int i = 0; i < 256; i++) ref_mem[i] = 'x;

        repeat (3) @(negedge CK);
        RST = 1'b0;
        @(negedge CK);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        check("rst_ctl", {27'd0, sram_cs, sram_we, spike_valid, clr_done, busy}, 32'd0);
        check("rst_a", 32'(sram_a), 32'd0);
        check("rst_d", sram_d, 32'd0);
        check("rst_spk_idx", 32'(spike_idx), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);

        preload(8'd5, 32'h0000_0005);
        event_chk(8'd5, 16'd3, 16'd10);
        preload(8'd9, 32'h0002_0008);
        event_chk(8'd9, 16'd4, 16'd10);
        preload(8'd17, 32'h0000_7FF0);
        event_chk(8'd17, 16'h0100, 16'h7FFF);
        preload(8'd18, 32'hFFFF_0020);
        event_chk(8'd18, 16'h0010, 16'h0020);
        preload(8'd19, 32'h0000_8010);
        event_chk(8'd19, 16'hFF00, 16'd10);
        preload(8'd20, 32'd160);
        event_chk(8'd20, 16'd0, 16'h7FFF);

        // Clear request and event in the same cycle: clear wins, event waits.
        preload(8'd3, 32'h00AA_0055);
        @(negedge CK);
        vth       = 16'd100;
        clr_start = 1'b1;
        in_valid  = 1'b1;
        in_idx    = 8'd3;
        in_wgt    = 16'd7;
        #1;
        check("clr_rdy", 32'(in_ready), 32'd0);
        @(posedge CK);
        @(negedge CK);
        clr_start = 1'b0;
        for (int k = 0; k < 256; k++) begin
            check("clr_wr", {sram_cs, sram_we, 6'd0, sram_a, sram_d[15:0]},
                  {2'b11, 6'd0, 8'(k), 16'd0});
            if (sram_d[31:16] !== 16'd0) check("clr_d_hi", 32'(sram_d[31:16]), 32'd0);
            if (k == 0) check("clr_busy", {30'd0, in_ready, busy}, 32'd1);
            @(negedge CK);
        end
        check("clr_done", {29'd0, clr_done, busy, in_ready}, 32'd5);
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 32'd0) nz++;
        check("clr_mem", 32'(nz), 32'd0);
        tail(8'd3, 16'd7);

        // Reset during WRITE drops the update.
        preload(8'd40, 32'h1234_0100);
        issue(8'd40, 16'd5, 16'd1000, ok);
        if (ok) begin
            @(posedge CK);
            @(negedge CK);
            in_valid = 1'b0;
            check("rw_rd", {30'd0, sram_cs, sram_we}, 32'd2);
            @(negedge CK);
            RST = 1'b1;
            @(negedge CK);
            RST = 1'b0;
            last_spike = '0;
            check("rw_mem", mem[40], 32'h1234_0100);
            check("rw_idle", {29'd0, busy, sram_cs, spike_valid}, 32'd0);
        end
        event_chk(8'd40, 16'd5, 16'd1000);

        for (int n = 0; n < 40; n++) begin
            int wi;
            int ti;
            wi = int'($urandom_range(0, 3000)) - 1500;
            ti = int'($urandom_range(0, 2500)) - 200;
            event_chk(8'($urandom_range(0, 15)), 16'(wi), 16'(ti));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
